// File: rtl/data_port_master_pkg.sv
// Shared encodings for the port-b data master: access sizes, FSM states, line geometry
// and the alignment rule used by both the request decoder and the lane mux.
package data_port_master_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_WRITE,
    ST_RESP
  } state_e;

  localparam int RAM_WIDTH_DEF = 128;
  localparam int LINE_BYTES    = RAM_WIDTH_DEF / 8;
  localparam int OFF_BITS      = $clog2(LINE_BYTES);

  function automatic int off_bits(input int ram_width);
    return $clog2(ram_width / 8);
  endfunction

  // Size 3 is illegal and reported the same way as a misaligned access.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      SZ_WORD: return |lo;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/line_lane_mux.sv
// Combinational lane extract (with sign/zero extend) and byte merge on one RAM line;
// zero latency, no flow control.
module line_lane_mux
  import data_port_master_pkg::*;
#(
  parameter int RAM_WIDTH = RAM_WIDTH_DEF,
  parameter int OFF_W     = off_bits(RAM_WIDTH)
) (
  input  logic [RAM_WIDTH-1:0] line,
  input  logic [OFF_W-1:0]     off,
  input  logic [1:0]           size,
  input  logic                 sign_ext,
  input  logic [31:0]          wdata,
  output logic [31:0]          rd_val,
  output logic [RAM_WIDTH-1:0] merged
);

  localparam int LB = RAM_WIDTH / 8;

  logic [31:0]          lane;
  logic [3:0]           size_mask;
  logic [LB-1:0]        byte_en;
  logic [RAM_WIDTH-1:0] bit_mask;
  logic [RAM_WIDTH-1:0] wide_wdata;

  always_comb begin
    lane = 32'(line >> {off, 3'b000});
    case (size)
      SZ_BYTE: rd_val = {{24{sign_ext & lane[7]}}, lane[7:0]};
      SZ_HALF: rd_val = {{16{sign_ext & lane[15]}}, lane[15:0]};
      default: rd_val = lane;
    endcase
  end

  // Aligned accesses never cross the line, so the shifted mask never wraps.
  always_comb begin
    case (size)
      SZ_BYTE: size_mask = 4'h1;
      SZ_HALF: size_mask = 4'h3;
      default: size_mask = 4'hF;
    endcase
    byte_en  = LB'(size_mask) << off;
    bit_mask = '0;
    for (int k = 0; k < LB; k++) begin
      bit_mask[8*k +: 8] = {8{byte_en[k]}};
    end
    wide_wdata = RAM_WIDTH'(wdata) << {off, 3'b000};
    merged     = (line & ~bit_mask) | (wide_wdata & bit_mask);
  end

endmodule

// File: rtl/data_port_master.sv
// Byte-addressed load/store to line-wide RAM port b: load 3 cycles, store 4 (RMW), error 1.
// One request in flight; req_ready only in IDLE; rdy=0 freezes every register.
module data_port_master
  import data_port_master_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int RAM_WIDTH  = RAM_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic                  rsp_err,
  output logic [31:0]           rsp_rdata,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic [RAM_WIDTH-1:0]  din_b,
  output logic                  we_b,
  input  logic [RAM_WIDTH-1:0]  dout_b
);

  localparam int OW = off_bits(RAM_WIDTH);

  state_e state, state_nxt;

  logic          we_q;
  logic          signed_q;
  logic          err_q;
  logic [1:0]    size_q;
  logic [OW-1:0] off_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;

  logic                 accept;
  logic                 req_bad;
  logic [31:0]          lane_val;
  logic [RAM_WIDTH-1:0] merged_line;
  logic                 unused_addr_hi;

  assign req_bad = misaligned(req_size, req_addr[1:0]);
  assign accept  = (state == ST_IDLE) && rdy && req_valid;

  // Address bits above the line index wrap modulo the RAM size.
  assign unused_addr_hi = ^req_addr[31:ADDR_WIDTH+OW];

  line_lane_mux #(
    .RAM_WIDTH (RAM_WIDTH),
    .OFF_W     (OW)
  ) u_lane_mux (
    .line     (dout_b),
    .off      (off_q),
    .size     (size_q),
    .sign_ext (signed_q),
    .wdata    (wdata_q),
    .rd_val   (lane_val),
    .merged   (merged_line)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else if (rdy) begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ISSUE;
      ST_ISSUE:   state_nxt = ST_CAPTURE;
      ST_CAPTURE: state_nxt = we_q ? ST_WRITE : ST_RESP;
      ST_WRITE:   state_nxt = ST_RESP;
      ST_RESP:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Ready is gated by rdy so a frozen block never appears to accept.
  always_comb begin
    req_ready = (state == ST_IDLE) && rdy;
    rsp_valid = (state == ST_RESP);
    rsp_err   = (state == ST_RESP) && err_q;
    rsp_rdata = (state == ST_RESP) ? rdata_q : 32'h0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q     <= 1'b0;
      signed_q <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= SZ_BYTE;
      off_q    <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      addr_b   <= '0;
      din_b    <= '0;
      we_b     <= 1'b0;
    end else if (rdy) begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            we_q     <= req_we;
            signed_q <= req_signed;
            err_q    <= req_bad;
            size_q   <= req_size;
            off_q    <= req_addr[OW-1:0];
            wdata_q  <= req_wdata;
            rdata_q  <= '0;
            if (!req_bad) addr_b <= req_addr[ADDR_WIDTH+OW-1:OW];
          end
        end
        ST_CAPTURE: begin
          if (we_q) begin
            din_b <= merged_line;
            we_b  <= 1'b1;
          end else begin
            rdata_q <= lane_val;
          end
        end
        ST_WRITE: we_b <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_port_master.sv
// Directed bench for data_port_master with a read-first synchronous line RAM model.
module tb_data_port_master;
  import data_port_master_pkg::*;

  localparam int AW = 17;
  localparam int RW = 128;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rdy = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [1:0]    req_size = 2'd0;
  logic          req_signed = 1'b0;
  logic [31:0]   req_addr = 32'h0;
  logic [31:0]   req_wdata = 32'h0;
  logic          rsp_valid;
  logic          rsp_err;
  logic [31:0]   rsp_rdata;
  logic [AW-1:0] addr_b;
  logic [RW-1:0] din_b;
  logic          we_b;
  logic [RW-1:0] dout_b;

  logic [RW-1:0] mem [0:255];

  int total = 0;
  int bad   = 0;

  data_port_master #(.ADDR_WIDTH(AW), .RAM_WIDTH(RW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rdy        (rdy),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_err    (rsp_err),
    .rsp_rdata  (rsp_rdata),
    .addr_b     (addr_b),
    .din_b      (din_b),
    .we_b       (we_b),
    .dout_b     (dout_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we_b) mem[addr_b[7:0]] <= din_b;
    dout_b <= mem[addr_b[7:0]];
  end

  // Byte j of line k starts as k ^ j.
  function automatic logic [RW-1:0] init_line(input int k);
    logic [RW-1:0] l;
    for (int j = 0; j < RW / 8; j++) l[8*j +: 8] = 8'(k) ^ 8'(j);
    return l;
  endfunction

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk128(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a negedge; returns at the negedge where rsp_valid is seen.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd,
                        output int lat, output logic err, output logic [31:0] rd,
                        output logic saw_we);
    int w;
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    w = 0;
    while (!req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    req_we = ~we; req_addr = $urandom; req_wdata = $urandom; req_size = 2'($urandom);
    lat = 1;
    saw_we = 1'b0;
    while (!rsp_valid && lat < 20) begin
      saw_we |= we_b;
      @(negedge clk);
      lat++;
    end
    if (!rsp_valid) lat = 99;
    saw_we |= we_b;
    err = rsp_err;
    rd  = rsp_rdata;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] addr;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
  } vec_t;

  localparam int NV = 13;
  vec_t vt [NV];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat;
    logic        err;
    logic [31:0] rd;
    logic        saw_we;
    logic [AW-1:0] prev_addr;
    logic [8:0]  rsp_m, rdy_m;
    logic [31:0] rd1, rd2;
    int          nrsp, nwe;
    logic        hold_ok;

    vt[0]  = '{1'b1, SZ_WORD, 1'b0, 32'h0000_0104, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000, 4};
    vt[1]  = '{1'b0, SZ_WORD, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 32'hDEAD_BEEF, 3};
    vt[2]  = '{1'b1, SZ_BYTE, 1'b0, 32'h0000_010F, 32'h1234_5680, 1'b0, 32'h0000_0000, 4};
    vt[3]  = '{1'b0, SZ_BYTE, 1'b1, 32'h0000_010F, 32'h0,         1'b0, 32'hFFFF_FF80, 3};
    vt[4]  = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_010F, 32'h0,         1'b0, 32'h0000_0080, 3};
    vt[5]  = '{1'b0, SZ_HALF, 1'b0, 32'h0000_0203, 32'h0,         1'b1, 32'h0000_0000, 1};
    vt[6]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_0106, 32'h0,         1'b0, 32'hFFFF_DEAD, 3};
    vt[7]  = '{1'b0, SZ_HALF, 1'b1, 32'h0000_0104, 32'h0,         1'b0, 32'hFFFF_BEEF, 3};
    vt[8]  = '{1'b0, 2'd3,    1'b0, 32'h0000_0200, 32'h0,         1'b1, 32'h0000_0000, 1};
    vt[9]  = '{1'b1, SZ_WORD, 1'b0, 32'h0000_0202, 32'h5555_5555, 1'b1, 32'h0000_0000, 1};
    vt[10] = '{1'b0, SZ_BYTE, 1'b0, 32'h0000_010E, 32'h0,         1'b0, 32'h0000_001E, 3};
    vt[11] = '{1'b0, SZ_WORD, 1'b0, 32'h0020_0108, 32'h0,         1'b0, 32'h1B1A_1918, 3};
    vt[12] = '{1'b0, SZ_HALF, 1'b0, 32'h0000_0104, 32'h0,         1'b0, 32'h0000_BEEF, 3};

    for (int k = 0; k < 256; k++) mem[k] <= init_line(k);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk32("rst_req_ready", 32'(req_ready), 32'd1);
    chk32("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk32("rst_rsp_err",   32'(rsp_err),   32'd0);
    chk32("rst_rsp_rdata", rsp_rdata,      32'd0);
    chk32("rst_addr_b",    32'(addr_b),    32'd0);
    chk128("rst_din_b",    din_b,          '0);
    chk32("rst_we_b",      32'(we_b),      32'd0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      prev_addr = addr_b;
      do_req(vt[i].we, vt[i].sz, vt[i].sg, vt[i].addr, vt[i].wd, lat, err, rd, saw_we);
      chk32($sformatf("v%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk32($sformatf("v%0d_err", i), 32'(err), 32'(vt[i].err));
      chk32($sformatf("v%0d_rdata", i), rd, vt[i].rd);
      chk32($sformatf("v%0d_we_seen", i), 32'(saw_we), 32'(vt[i].we && !vt[i].err));
      if (vt[i].err) chk32($sformatf("v%0d_addr_hold", i), 32'(addr_b), 32'(prev_addr));
      @(negedge clk);
      chk32($sformatf("v%0d_pulse_end", i), 32'(rsp_valid), 32'd0);
    end

    chk128("line10_merged", mem[8'h10], 128'h801E1D1C_1B1A1918_DEADBEEF_13121110);
    chk128("line11_intact", mem[8'h11], init_line(8'h11));
    chk128("line20_intact", mem[8'h20], init_line(8'h20));

    // Back-to-back loads with req_valid held high
    req_we = 1'b0; req_size = SZ_WORD; req_signed = 1'b0; req_addr = 32'h104;
    req_valid = 1'b1;
    rsp_m = '0; rdy_m = '0; rd1 = '0; rd2 = '0;
    @(posedge clk);
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      rsp_m[c] = rsp_valid;
      rdy_m[c] = req_ready;
      if (c == 3) rd1 = rsp_rdata;
      if (c == 7) rd2 = rsp_rdata;
      if (c == 1) req_addr = 32'h20C;
      if (c == 5) req_valid = 1'b0;
    end
    chk32("b2b_rsp_cycles",   32'(rsp_m), 32'h088);
    chk32("b2b_ready_cycles", 32'(rdy_m), 32'h110);
    chk32("b2b_rdata1", rd1, 32'hDEAD_BEEF);
    chk32("b2b_rdata2", rd2, 32'h2F2E_2D2C);

    // Reset during CAPTURE of a store
    req_we = 1'b1; req_size = SZ_WORD; req_addr = 32'h308; req_wdata = 32'h1122_3344;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk32("midrst_we_b",      32'(we_b),      32'd0);
    chk32("midrst_addr_b",    32'(addr_b),    32'd0);
    chk32("midrst_req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    nrsp = 0; nwe = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      nrsp += int'(rsp_valid);
      nwe  += int'(we_b);
    end
    chk32("midrst_no_rsp", 32'(nrsp), 32'd0);
    chk32("midrst_no_we",  32'(nwe),  32'd0);
    chk128("midrst_line30", mem[8'h30], init_line(8'h30));
    do_req(1'b0, SZ_WORD, 1'b0, 32'h308, 32'h0, lat, err, rd, saw_we);
    chk32("midrst_readback", rd, 32'h3B3A_3938);
    @(negedge clk);

    // rdy low for 5 cycles during WRITE
    req_we = 1'b1; req_size = SZ_HALF; req_addr = 32'h20A; req_wdata = 32'h0000_CAFE;
    req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk32("stall_in_write", 32'(we_b), 32'd1);
    rdy = 1'b0;
    hold_ok = 1'b1;
    nrsp = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!we_b || rsp_valid || addr_b != AW'(17'h20) || req_ready) hold_ok = 1'b0;
    end
    chk32("stall_hold", 32'(hold_ok), 32'd1);
    rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      nrsp += int'(rsp_valid);
    end
    chk32("stall_rsp_count", 32'(nrsp), 32'd1);
    chk128("stall_line20", mem[8'h20], 128'h2F2E2D2C_CAFE2928_27262524_23222120);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
